// File: rtl/matrix_scroll_ctrl.sv
// LED-matrix scroll sequencer: column-scan timing, scroll offset/direction and run/hold/config
// handshake; reads column patterns from a 1-cycle synchronous ROM and drives segout/scanout.
module matrix_scroll_ctrl #(
  parameter int SCAN_DIV        = 8192,
  parameter int FRAMES_PER_STEP = 64,
  parameter int ADDR_W          = 6
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_cfg_valid,
  output logic              o_cfg_ready,
  input  logic [ADDR_W-1:0] i_cfg_len,
  input  logic              i_cfg_dir,
  output logic              o_cfg_err,
  input  logic              i_run,
  output logic [ADDR_W-1:0] o_rom_addr,
  input  logic [7:0]        i_rom_data,
  output logic [7:0]        o_segout,
  output logic [2:0]        o_scanout,
  output logic              o_step_pulse,
  output logic              o_wrap_pulse
);
  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int FRM_W = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, HOLD = 2'd2} state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [DIV_W-1:0]   r_div;
  logic [2:0]         r_col;
  logic [FRM_W-1:0]   r_frame;
  logic [ADDR_W-1:0]  r_offset;
  logic [ADDR_W-1:0]  r_len;
  logic               r_dir;

  logic               w_cfg_hs;
  logic               w_cfg_ok;
  logic               w_cfg_bad;
  logic               w_restart;
  logic               w_div_wrap;
  logic               w_addr_tick;
  logic [2:0]         w_col_next;
  logic               w_frame_end;
  logic               w_step;
  logic               w_wrap;
  logic [ADDR_W:0]    w_sum;
  logic [ADDR_W:0]    w_addr;
  logic [ADDR_W-1:0]  w_offset_next;

  assign w_cfg_hs    = i_cfg_valid & o_cfg_ready;
  assign w_cfg_ok    = w_cfg_hs & (i_cfg_len >= ADDR_W'(8));
  assign w_cfg_bad   = w_cfg_hs & ~w_cfg_ok;
  assign w_restart   = w_cfg_ok & (r_state == HOLD);
  assign w_div_wrap  = (r_div == DIV_W'(SCAN_DIV - 1));
  assign w_addr_tick = (r_div == DIV_W'(SCAN_DIV - 3));
  assign w_col_next  = r_col + 3'd1;
  assign w_frame_end = w_div_wrap & (r_col == 3'd7);
  assign w_step      = (r_state == RUN) & w_frame_end & (r_frame == FRM_W'(FRAMES_PER_STEP - 1));

  // offset < len and col <= 7 < len, so one conditional subtract is a full modulo
  assign w_sum  = {1'b0, r_offset} + {{(ADDR_W-2){1'b0}}, w_col_next};
  assign w_addr = (w_sum >= {1'b0, r_len}) ? (w_sum - {1'b0, r_len}) : w_sum;

  assign w_offset_next = r_dir ? ((r_offset == '0) ? (r_len - ADDR_W'(1)) : (r_offset - ADDR_W'(1)))
                               : ((r_offset == (r_len - ADDR_W'(1))) ? '0 : (r_offset + ADDR_W'(1)));
  assign w_wrap = r_dir ? (r_offset == '0) : (r_offset == (r_len - ADDR_W'(1)));

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) r_state <= IDLE;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_cfg_ok) w_state_next = i_run ? RUN : HOLD;
      RUN:     if (!i_run)   w_state_next = HOLD;
      HOLD:    if (i_run)    w_state_next = RUN;
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    o_cfg_ready = (r_state == IDLE) || (r_state == HOLD);
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_div        <= '0;
      r_col        <= '0;
      r_frame      <= '0;
      r_offset     <= '0;
      r_len        <= ADDR_W'(8);
      r_dir        <= 1'b0;
      o_segout     <= 8'hFF;
      o_scanout    <= '0;
      o_rom_addr   <= '0;
      o_cfg_err    <= 1'b0;
      o_step_pulse <= 1'b0;
      o_wrap_pulse <= 1'b0;
    end else begin
      o_cfg_err    <= w_cfg_bad;
      o_step_pulse <= w_step;
      o_wrap_pulse <= w_step & w_wrap;

      if (w_restart) begin
        r_div     <= '0;
        r_col     <= '0;
        o_scanout <= '0;
        o_segout  <= 8'hFF;
      end else begin
        r_div <= w_div_wrap ? '0 : (r_div + DIV_W'(1));
        if (w_addr_tick) o_rom_addr <= w_addr[ADDR_W-1:0];
        if (w_div_wrap) begin
          r_col     <= w_col_next;
          o_scanout <= w_col_next;
          o_segout  <= (r_state == IDLE) ? 8'hFF : i_rom_data;
        end
      end

      // offset only moves on a frame boundary, so a column never shows a half-updated frame
      if (w_cfg_ok) begin
        r_len    <= i_cfg_len;
        r_dir    <= i_cfg_dir;
        r_offset <= '0;
        r_frame  <= '0;
      end else if ((r_state == RUN) && w_frame_end) begin
        if (w_step) begin
          r_frame  <= '0;
          r_offset <= w_offset_next;
        end else begin
          r_frame <= r_frame + FRM_W'(1);
        end
      end
    end
  end
endmodule

// File: tb/tb_matrix_scroll_ctrl.sv
// Bench for matrix_scroll_ctrl: directed scenarios plus random run/config traffic, every output
// cycle scored against a slot/frame-level reference model through an expectation queue.
module tb_matrix_scroll_ctrl;
  localparam int SD  = 4;
  localparam int FPS = 2;
  localparam int AW  = 6;
  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_HOLD = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          cfg_valid;
  logic          cfg_ready;
  logic [AW-1:0] cfg_len;
  logic          cfg_dir;
  logic          cfg_err;
  logic          run;
  logic [AW-1:0] rom_addr;
  logic [7:0]    rom_data;
  logic [7:0]    segout;
  logic [2:0]    scanout;
  logic          step_pulse;
  logic          wrap_pulse;

  always #5 clk = ~clk;

  // pattern ROM: ROM[k] = k, one clock of latency
  always @(posedge clk) rom_data <= {2'b00, rom_addr};

  matrix_scroll_ctrl #(.SCAN_DIV(SD), .FRAMES_PER_STEP(FPS), .ADDR_W(AW)) dut (
    .i_clk(clk), .i_reset(reset), .i_cfg_valid(cfg_valid), .o_cfg_ready(cfg_ready),
    .i_cfg_len(cfg_len), .i_cfg_dir(cfg_dir), .o_cfg_err(cfg_err), .i_run(run),
    .o_rom_addr(rom_addr), .i_rom_data(rom_data), .o_segout(segout), .o_scanout(scanout),
    .o_step_pulse(step_pulse), .o_wrap_pulse(wrap_pulse)
  );

  typedef struct packed {
    logic [7:0]    seg;
    logic [2:0]    scan;
    logic [AW-1:0] addr;
    logic          rdy;
    logic          err;
    logic          step;
    logic          wrap;
  } obs_t;

  obs_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   steps_seen = 0;
  int   wraps_seen = 0;

  // reference model: time since scan epoch, mode, scroll settings, frames since last step
  int   m_t, m_mode, m_len, m_dir, m_off, m_frames;
  obs_t m_o;

  task automatic model_reset();
    m_t = 0; m_mode = M_IDLE; m_len = 8; m_dir = 0; m_off = 0; m_frames = 0;
    m_o = '{seg: 8'hFF, scan: 3'd0, addr: '0, rdy: 1'b1, err: 1'b0, step: 1'b0, wrap: 1'b0};
  endtask

  task automatic model_edge();
    int phase, col, ncol, old;
    bit hs, ok;
    phase = m_t % SD;
    col   = (m_t / SD) % 8;
    ncol  = (col + 1) % 8;
    hs    = cfg_valid && (m_mode != M_RUN);
    ok    = hs && (int'(cfg_len) >= 8);
    m_o.err  = hs && !ok;
    m_o.step = 1'b0;
    m_o.wrap = 1'b0;
    if (ok && m_mode == M_HOLD) begin
      m_t = 0; m_o.scan = 3'd0; m_o.seg = 8'hFF;
    end else begin
      if (phase == SD - 3) m_o.addr = AW'((m_off + ncol) % m_len);
      if (phase == SD - 1) begin
        m_o.scan = 3'(ncol);
        m_o.seg  = (m_mode == M_IDLE) ? 8'hFF : 8'((m_off + ncol) % m_len);
      end
      m_t++;
    end
    if (ok) begin
      m_len = int'(cfg_len); m_dir = int'(cfg_dir); m_off = 0; m_frames = 0;
    end else if (m_mode == M_RUN && phase == SD - 1 && col == 7) begin
      m_frames++;
      if (m_frames == FPS) begin
        m_frames = 0;
        old   = m_off;
        m_off = m_dir ? (m_off + m_len - 1) % m_len : (m_off + 1) % m_len;
        m_o.step = 1'b1;
        m_o.wrap = m_dir ? (old == 0) : (m_off == 0);
      end
    end
    if (m_mode == M_IDLE) begin
      if (ok) m_mode = run ? M_RUN : M_HOLD;
    end else if (m_mode == M_RUN) begin
      if (!run) m_mode = M_HOLD;
    end else if (run) begin
      m_mode = M_RUN;
    end
    m_o.rdy = (m_mode != M_RUN);
    exp_q.push_back(m_o);
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_segout"}, 32'(segout), 32'hFF);
    chk({tag, "_scanout"}, 32'(scanout), 32'h0);
    chk({tag, "_rom_addr"}, 32'(rom_addr), 32'h0);
    chk({tag, "_cfg_ready"}, 32'(cfg_ready), 32'h1);
    chk({tag, "_pulses"}, {29'd0, cfg_err, step_pulse, wrap_pulse}, 32'h0);
  endtask

  // monitor: the DUT presents a full output word every cycle
  always begin : monitor
    obs_t e, a;
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {segout, scanout, rom_addr, cfg_ready, cfg_err, step_pulse, wrap_pulse};
      if (step_pulse) steps_seen++;
      if (wrap_pulse) wraps_seen++;
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL cycle@%0t: seg %h/%h scan %0d/%0d addr %0d/%0d rdy %b/%b err %b/%b step %b/%b wrap %b/%b (got/expected)",
                 $time, a.seg, e.seg, a.scan, e.scan, a.addr, e.addr, a.rdy, e.rdy,
                 a.err, e.err, a.step, e.step, a.wrap, e.wrap);
      end
    end
  end

  task automatic send_cfg(input int len, input bit dir);
    cfg_valid = 1'b1; cfg_len = AW'(len); cfg_dir = dir;
    tick();
    cfg_valid = 1'b0;
  endtask

  initial begin
    int s0, w0;
    bit found;
    reset = 1'b0; cfg_valid = 1'b0; cfg_len = '0; cfg_dir = 1'b0; run = 1'b0;
    model_reset();
    @(negedge clk); @(negedge clk);
    #1 check_reset_outputs("por");
    @(negedge clk);
    reset = 1'b1;

    // idle: blank display, scan keeps cycling
    repeat (100) tick();

    // short message rejected in IDLE
    send_cfg(5, 1'b0);
    repeat (40) tick();

    // scroll left over len=10 through a full offset wrap
    run = 1'b1;
    w0 = wraps_seen;
    send_cfg(10, 1'b0);
    repeat (720) tick();
    chk("left_wrap_seen", 32'(wraps_seen - w0 > 0), 32'h1);

    // reconfigure from HOLD: scroll right, first step wraps 0 -> 9
    run = 1'b0;
    tick();
    send_cfg(10, 1'b1);
    run = 1'b1;
    repeat (250) tick();

    // hold mid-frame for 10 frames: no steps while held
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (m_mode == M_RUN && (m_t % (8 * SD)) == 13) found = 1'b1;
      else tick();
    end
    chk("hold_align_found", 32'(found), 32'h1);
    run = 1'b0;
    tick();
    s0 = steps_seen;
    repeat (10 * 8 * SD) tick();
    chk("hold_no_steps", 32'(steps_seen - s0), 32'h0);
    send_cfg(4, 1'b0);
    run = 1'b1;
    repeat (200) tick();

    // random run/config traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) run = ~run;
      if ($urandom_range(0, 29) == 0) send_cfg($urandom_range(3, 63), 1'($urandom_range(0, 1)));
      else tick();
    end

    // asynchronous reset mid-frame at div=2, col=5
    run = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      if (m_mode == M_RUN && (m_t % SD) == 2 && ((m_t / SD) % 8) == 5) found = 1'b1;
      else tick();
    end
    chk("reset_align_found", 32'(found), 32'h1);
    reset = 1'b0;
    #1 check_reset_outputs("midreset");
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (60) tick();

    @(posedge clk);
    #2;
    chk("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
